// File: rtl/block_mover.sv
// Falling-block mover: slides a block left/right across a row, lands it on
// a player drop, checks overlap against the previous landing and sequences
// rows until a miss (game over) or a full stack (win).
//
// state | meaning
// ------+-----------------------------------------------------------
// LOAD  | latch start x/y/direction of the current row
// MOVE  | step the block on tick, bounce at the edges, wait for drop
// LAND  | evaluate overlap, record landing, pulse inc_row on success
// WAIT  | one idle cycle so the upstream row counter can advance
// OVER  | failed landing, absorbing until reset
// DONE  | all rows landed, absorbing until reset
module block_mover #(
  parameter logic [7:0] X_MAX    = 8'd144,
  parameter logic [7:0] BLOCK_W  = 8'd16,
  parameter logic [7:0] STEP     = 8'd2,
  parameter logic [2:0] NUM_ROWS = 3'd7
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic       drop,
  input  logic       new_direction,
  input  logic [7:0] new_x_position,
  input  logic [6:0] new_y_position,
  output logic       inc_row,
  output logic [7:0] x_pos,
  output logic [6:0] y_pos,
  output logic [7:0] landed_x,
  output logic       game_over,
  output logic       win
);

  typedef enum logic [2:0] {
    S_LOAD, S_MOVE, S_LAND, S_WAIT, S_OVER, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic       dir_q, dir_d;
  logic [7:0] landed_q, landed_d;
  logic [2:0] rows_q, rows_d;
  logic       inc_row_q, inc_row_d;
  logic       game_over_q, game_over_d;
  logic       win_q, win_d;

  logic [8:0] right_sum;
  logic [8:0] diff9;
  logic [3:0] rows_next;
  logic       land_ok;
  logic       more_rows;

  // Overlap and row-count helpers; 9-bit so no comparison can wrap.
  always_comb begin
    right_sum = {1'b0, x_q} + {1'b0, STEP};
    if (x_q >= landed_q) diff9 = {1'b0, x_q} - {1'b0, landed_q};
    else                 diff9 = {1'b0, landed_q} - {1'b0, x_q};
    land_ok   = (rows_q == 3'd0) || (diff9 < {1'b0, BLOCK_W});
    rows_next = {1'b0, rows_q} + 4'd1;
    more_rows = rows_next < {1'b0, NUM_ROWS};
  end

  // Next-state and next-output computation for the mover FSM.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_d       = dir_q;
    landed_d    = landed_q;
    rows_d      = rows_q;
    inc_row_d   = 1'b0;
    game_over_d = game_over_q;
    win_d       = win_q;
    case (state_q)
      S_LOAD: begin
        x_d     = new_x_position;
        y_d     = new_y_position;
        dir_d   = new_direction;
        state_d = S_MOVE;
      end
      S_MOVE: begin
        if (drop) begin
          // x is frozen from here on, so the landing verdict is known now and
          // inc_row can be registered to coincide with the LAND cycle.
          state_d   = S_LAND;
          inc_row_d = land_ok && more_rows;
        end else if (tick) begin
          if (dir_q) begin
            if (right_sum >= {1'b0, X_MAX}) begin
              x_d   = X_MAX;
              dir_d = 1'b0;
            end else begin
              x_d = right_sum[7:0];
            end
          end else begin
            if (x_q > STEP) begin
              x_d = x_q - STEP;
            end else begin
              x_d   = 8'd0;
              dir_d = 1'b1;
            end
          end
        end
      end
      S_LAND: begin
        if (land_ok) begin
          landed_d = x_q;
          rows_d   = rows_next[2:0];
          if (more_rows) begin
            state_d = S_WAIT;
          end else begin
            win_d   = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          game_over_d = 1'b1;
          state_d     = S_OVER;
        end
      end
      S_WAIT:  state_d = S_LOAD;
      S_OVER:  state_d = S_OVER;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_LOAD;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_LOAD;
      x_q         <= 8'd0;
      y_q         <= 7'd0;
      dir_q       <= 1'b1;
      landed_q    <= 8'd0;
      rows_q      <= 3'd0;
      inc_row_q   <= 1'b0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      landed_q    <= landed_d;
      rows_q      <= rows_d;
      inc_row_q   <= inc_row_d;
      game_over_q <= game_over_d;
      win_q       <= win_d;
    end
  end

  assign inc_row   = inc_row_q;
  assign x_pos     = x_q;
  assign y_pos     = y_q;
  assign landed_x  = landed_q;
  assign game_over = game_over_q;
  assign win       = win_q;

endmodule

// File: tb/tb_block_mover.sv
// Directed bench for block_mover: reset, movement, edge handling, landing
// outcomes, drop priority/discard and the full win sequence.
module tb_block_mover;

  logic       clk;
  logic       resetn;
  logic       tick;
  logic       drop;
  logic       new_direction;
  logic [7:0] new_x_position;
  logic [6:0] new_y_position;
  logic       inc_row;
  logic [7:0] x_pos;
  logic [6:0] y_pos;
  logic [7:0] landed_x;
  logic       game_over;
  logic       win;

  int tests_run;
  int tests_failed;

  block_mover dut (
    .clk            (clk),
    .resetn         (resetn),
    .tick           (tick),
    .drop           (drop),
    .new_direction  (new_direction),
    .new_x_position (new_x_position),
    .new_y_position (new_y_position),
    .inc_row        (inc_row),
    .x_pos          (x_pos),
    .y_pos          (y_pos),
    .landed_x       (landed_x),
    .game_over      (game_over),
    .win            (win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges with the given row inputs; leaves the DUT in LOAD.
  task automatic apply_reset(input logic dir, input logic [7:0] x, input logic [6:0] y);
    resetn         = 1'b0;
    tick           = 1'b0;
    drop           = 1'b0;
    new_direction  = dir;
    new_x_position = x;
    new_y_position = y;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic do_drop();
    drop = 1'b1;
    step();
    drop = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(1'b1, 8'd0, 7'd104);
    tests_run++;
    if ({x_pos, y_pos, landed_x, inc_row, game_over, win} !== 27'd0) begin
      tests_failed++;
      $display("FAIL reset_values: x=%0d y=%0d lx=%0d inc=%0b go=%0b win=%0b expected all 0",
               x_pos, y_pos, landed_x, inc_row, game_over, win);
    end
  endtask

  task automatic test_start_row();
    step();
    tests_run++;
    if (x_pos !== 8'd0 || y_pos !== 7'd104) begin
      tests_failed++;
      $display("FAIL start_load: x=%0d y=%0d expected x=0 y=104", x_pos, y_pos);
    end
    for (int i = 0; i < 10; i++) do_tick();
    tests_run++;
    if (x_pos !== 8'd20) begin
      tests_failed++;
      $display("FAIL start_ticks: x=%0d expected 20", x_pos);
    end
  endtask

  task automatic test_right_bounce();
    apply_reset(1'b1, 8'd142, 7'd3);
    step();
    do_tick();
    tests_run++;
    if (x_pos !== 8'd144) begin
      tests_failed++;
      $display("FAIL right_clamp: x=%0d expected 144", x_pos);
    end
    do_tick();
    tests_run++;
    if (x_pos !== 8'd142) begin
      tests_failed++;
      $display("FAIL right_bounce: x=%0d expected 142", x_pos);
    end
  endtask

  task automatic test_left_clamp();
    apply_reset(1'b0, 8'd1, 7'd3);
    step();
    do_tick();
    tests_run++;
    if (x_pos !== 8'd0) begin
      tests_failed++;
      $display("FAIL left_clamp: x=%0d expected 0", x_pos);
    end
    do_tick();
    tests_run++;
    if (x_pos !== 8'd2) begin
      tests_failed++;
      $display("FAIL left_bounce: x=%0d expected 2", x_pos);
    end
  endtask

  task automatic test_landing_sequence();
    apply_reset(1'b1, 8'd40, 7'd10);
    step();
    do_drop();
    tests_run++;
    if (inc_row !== 1'b1 || x_pos !== 8'd40) begin
      tests_failed++;
      $display("FAIL land_row0: inc=%0b x=%0d expected inc=1 x=40", inc_row, x_pos);
    end
    new_x_position = 8'd50;
    step();
    tests_run++;
    if (inc_row !== 1'b0 || landed_x !== 8'd40) begin
      tests_failed++;
      $display("FAIL wait_row0: inc=%0b lx=%0d expected inc=0 lx=40", inc_row, landed_x);
    end
    step();
    step();
    tests_run++;
    if (x_pos !== 8'd50) begin
      tests_failed++;
      $display("FAIL load_row1: x=%0d expected 50", x_pos);
    end
    do_drop();
    tests_run++;
    if (inc_row !== 1'b1) begin
      tests_failed++;
      $display("FAIL land_row1: inc=%0b expected 1", inc_row);
    end
    new_x_position = 8'd66;
    step();
    tests_run++;
    if (inc_row !== 1'b0 || landed_x !== 8'd50) begin
      tests_failed++;
      $display("FAIL wait_row1: inc=%0b lx=%0d expected inc=0 lx=50", inc_row, landed_x);
    end
    step();
    step();
    do_drop();
    tests_run++;
    if (inc_row !== 1'b0) begin
      tests_failed++;
      $display("FAIL land_row2_miss: inc=%0b expected 0", inc_row);
    end
    step();
    tests_run++;
    if (game_over !== 1'b1 || win !== 1'b0 || landed_x !== 8'd50) begin
      tests_failed++;
      $display("FAIL game_over: go=%0b win=%0b lx=%0d expected go=1 win=0 lx=50",
               game_over, win, landed_x);
    end
    tick = 1'b1;
    drop = 1'b1;
    step();
    step();
    step();
    tick = 1'b0;
    drop = 1'b0;
    tests_run++;
    if (x_pos !== 8'd66 || game_over !== 1'b1 || inc_row !== 1'b0) begin
      tests_failed++;
      $display("FAIL over_hold: x=%0d go=%0b inc=%0b expected x=66 go=1 inc=0",
               x_pos, game_over, inc_row);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset(1'b1, 8'd30, 7'd20);
    step();
    tick = 1'b1;
    drop = 1'b1;
    step();
    tick = 1'b0;
    drop = 1'b0;
    tests_run++;
    if (x_pos !== 8'd30 || inc_row !== 1'b1) begin
      tests_failed++;
      $display("FAIL tick_drop_priority: x=%0d inc=%0b expected x=30 inc=1", x_pos, inc_row);
    end
    step();
    drop = 1'b1;
    step();
    drop = 1'b0;
    step();
    tests_run++;
    if (inc_row !== 1'b0 || x_pos !== 8'd30) begin
      tests_failed++;
      $display("FAIL wait_drop_discard: inc=%0b x=%0d expected inc=0 x=30", inc_row, x_pos);
    end
    do_tick();
    tests_run++;
    if (x_pos !== 8'd32 || inc_row !== 1'b0) begin
      tests_failed++;
      $display("FAIL move_after_discard: x=%0d inc=%0b expected x=32 inc=0", x_pos, inc_row);
    end
  endtask

  task automatic test_reset_mid_land();
    apply_reset(1'b1, 8'd40, 7'd5);
    step();
    do_drop();
    tests_run++;
    if (inc_row !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_land_pre: inc=%0b expected 1", inc_row);
    end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    tests_run++;
    if (inc_row !== 1'b0 || x_pos !== 8'd0 || landed_x !== 8'd0) begin
      tests_failed++;
      $display("FAIL mid_land_reset: inc=%0b x=%0d lx=%0d expected 0 0 0", inc_row, x_pos, landed_x);
    end
  endtask

  task automatic test_win();
    int pulses;
    pulses = 0;
    apply_reset(1'b1, 8'd40, 7'd60);
    step();
    for (int i = 0; i < 7; i++) begin
      do_drop();
      if (inc_row === 1'b1) pulses++;
      if (i < 6) begin
        step();
        if (inc_row === 1'b1) pulses++;
        step();
        step();
      end
    end
    tests_run++;
    if (pulses !== 6) begin
      tests_failed++;
      $display("FAIL win_pulses: inc_row pulses=%0d expected 6", pulses);
    end
    step();
    tests_run++;
    if (win !== 1'b1 || game_over !== 1'b0 || inc_row !== 1'b0 || landed_x !== 8'd40) begin
      tests_failed++;
      $display("FAIL win_done: win=%0b go=%0b inc=%0b lx=%0d expected 1 0 0 40",
               win, game_over, inc_row, landed_x);
    end
    tick = 1'b1;
    step();
    step();
    tick = 1'b0;
    tests_run++;
    if (x_pos !== 8'd40 || y_pos !== 7'd60 || win !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_hold: x=%0d y=%0d win=%0b expected 40 60 1", x_pos, y_pos, win);
    end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    tests_run++;
    if ({x_pos, y_pos, landed_x, inc_row, game_over, win} !== 27'd0) begin
      tests_failed++;
      $display("FAIL done_reset: x=%0d y=%0d lx=%0d inc=%0b go=%0b win=%0b expected all 0",
               x_pos, y_pos, landed_x, inc_row, game_over, win);
    end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    resetn         = 1'b0;
    tick           = 1'b0;
    drop           = 1'b0;
    new_direction  = 1'b1;
    new_x_position = 8'd0;
    new_y_position = 7'd0;
    test_reset();
    test_start_row();
    test_right_bounce();
    test_left_clamp();
    test_landing_sequence();
    test_back_to_back();
    test_reset_mid_land();
    test_win();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/block_mover.md
BLOCK_MOVER -- requirements
Module: block_mover

Interface

Parameters:
- REQ-001: The block SHALL have parameter X_MAX, default 8'd144, the rightmost legal block x position.
- REQ-002: The block SHALL have parameter BLOCK_W, default 8'd16, the block width in pixels, used for the overlap check.
- REQ-003: The block SHALL have parameter STEP, default 8'd2, the pixels moved per tick.
- REQ-004: The block SHALL have parameter NUM_ROWS, default 3'd7, the number of landings needed to win.

Ports (name, direction, width, meaning):
- REQ-005: The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
- REQ-006: The block SHALL have port resetn, input, 1; reset is synchronous and active-low.
- REQ-007: The block SHALL have port tick, input, 1, a one-cycle movement strobe (frame rate).
- REQ-008: The block SHALL have port drop, input, 1, a one-cycle player drop request.
- REQ-009: The block SHALL have port new_direction, input, 1, the start direction of the current row (0 = left, 1 = right).
- REQ-010: The block SHALL have port new_x_position, input, 8, the start x of the current row.
- REQ-011: The block SHALL have port new_y_position, input, 7, the y of the current row.
- REQ-012: The block SHALL have port inc_row, output, 1, a one-cycle request to advance the row counter upstream.
- REQ-013: The block SHALL have port x_pos, output, 8, the current block x for the renderer.
- REQ-014: The block SHALL have port y_pos, output, 7, the current block y for the renderer.
- REQ-015: The block SHALL have port landed_x, output, 8, the x of the most recent successful landing.
- REQ-016: The block SHALL have port game_over, output, 1; it is high and held from a failed landing until reset.
- REQ-017: The block SHALL have port win, output, 1; it is high and held after NUM_ROWS successful landings until reset.

Function

- REQ-018: The FSM SHALL have the states LOAD, MOVE, LAND, WAIT, OVER and DONE.
- REQ-019: In LOAD, the block SHALL latch x_pos from new_x_position, y_pos from new_y_position and the direction register from new_direction, then go to MOVE the next cycle.
- REQ-020: In MOVE with tick=1 and direction right, x_pos SHALL become min(x_pos+STEP, X_MAX); if the result equals X_MAX, direction SHALL become left in the same edge.
- REQ-021: In MOVE with tick=1 and direction left, x_pos SHALL become x_pos-STEP if x_pos>STEP, else 0 with direction set to right; x_pos SHALL never underflow or exceed X_MAX.
- REQ-022: All arithmetic SHALL be 8-bit unsigned; comparisons SHALL use a 9-bit intermediate so no wrap-around occurs.
- REQ-023: In MOVE with drop=1, the block SHALL go to LAND and freeze x_pos; drop SHALL take priority over a simultaneous tick, so x_pos is not stepped in that cycle.
- REQ-024: In LAND, a landing SHALL succeed if the row count is 0, or if |x_pos - landed_x| < BLOCK_W.
- REQ-025: On a successful landing, landed_x SHALL be set to x_pos and the row count SHALL increment.
- REQ-026: On a successful landing where the new row count < NUM_ROWS, inc_row SHALL be high for exactly that LAND cycle and the next state SHALL be WAIT.
- REQ-027: On a successful landing where the new row count equals NUM_ROWS, win SHALL be set, inc_row SHALL stay 0, and the next state SHALL be DONE.
- REQ-028: On a failed landing, game_over SHALL be set, inc_row SHALL stay 0, and the next state SHALL be OVER.
- REQ-029: WAIT SHALL last one cycle, giving the upstream row counter time to update, then go to LOAD.
- REQ-030: Latency SHALL be: drop in cycle n -> LAND with inc_row in n+1 -> WAIT in n+2 -> LOAD samples the new row in n+3 -> MOVE in n+4.
- REQ-031: OVER and DONE SHALL be absorbing; tick and drop SHALL be ignored, and x_pos and y_pos SHALL hold.
- REQ-032: tick and drop SHALL be ignored in LOAD, LAND and WAIT; a drop there is discarded, not queued.
- REQ-033: The row count SHALL be a 3-bit register and SHALL never exceed NUM_ROWS.

Reset

- REQ-034: When resetn=0 at a rising edge, the block SHALL set state=LOAD, x_pos=0, y_pos=0, direction=right, landed_x=0, row count=0, inc_row=0, game_over=0 and win=0.
- REQ-035: Reset SHALL take effect in any state, including mid-MOVE, LAND, OVER or DONE, and any pending inc_row SHALL be cancelled.
- REQ-036: The first LOAD after reset SHALL sample the new_* inputs present on that cycle.

Verification

- REQ-037: Reset then start row: reset, inputs (dir=1, x=0, y=104) -> MOVE with x_pos=0, y_pos=104; 10 ticks -> x_pos=20.
- REQ-038: Right-edge bounce: x_pos=142 moving right, tick -> x_pos=144 and direction left; next tick -> x_pos=142.
- REQ-039: Left-edge clamp: x_pos=1 moving left, tick -> x_pos=0 and direction right; no underflow to 255.
- REQ-040: Landing sequence: land row 0 at x=40, then drop row 1 at x=50 -> inc_row high for one cycle, landed_x=50; drop row 2 at x=66 -> game_over=1, no inc_row, and x_pos held on further ticks.
- REQ-041: Simultaneous tick and drop at x_pos=30 -> LAND with x_pos=30; a drop during WAIT is ignored.
- REQ-042: Seven aligned drops -> inc_row pulses 6 times, then win=1 in DONE; resetn=0 during DONE -> all outputs return to their reset values.
